// File: rtl/dllp_tx_if.sv
// Bundles the DLLP scheduler's request inputs, DLLP output channel and status flags.
// The scheduler connects through 'slave'; whatever drives requests and consumes DLLPs uses 'master'.
interface dllp_tx_if;
    logic        ack_req;
    logic [11:0] ack_seq;
    logic        nak_req;
    logic [11:0] nak_seq;
    logic        fc_update_valid;
    logic [1:0]  fc_type;
    logic [7:0]  fc_hdr;
    logic [11:0] fc_data;
    logic [31:0] dllp_o;
    logic        dllp_valid;
    logic        dllp_ready;
    logic        ack_pending_o;
    logic        nak_pending_o;

    modport slave (
        input  ack_req, ack_seq, nak_req, nak_seq,
        input  fc_update_valid, fc_type, fc_hdr, fc_data,
        input  dllp_ready,
        output dllp_o, dllp_valid, ack_pending_o, nak_pending_o
    );

    modport master (
        output ack_req, ack_seq, nak_req, nak_seq,
        output fc_update_valid, fc_type, fc_hdr, fc_data,
        output dllp_ready,
        input  dllp_o, dllp_valid, ack_pending_o, nak_pending_o
    );
endinterface

// File: rtl/dllp_tx_scheduler.sv
// Shares one DLLP output channel between NAKs, coalesced ACKs and round-robin FC updates.
// FC updates are also re-sent periodically so the link partner's credit view never goes stale.
module dllp_tx_scheduler #(
    parameter int ACK_LATENCY  = 64,
    parameter int ACK_COALESCE = 4,
    parameter int FC_REFRESH   = 1024
) (
    input  logic      clk,
    input  logic      reset,
    dllp_tx_if.slave  bus
);
    localparam int TW = $clog2(ACK_LATENCY);
    localparam int CW = $clog2(ACK_COALESCE + 1);
    localparam int RW = $clog2(FC_REFRESH);
    localparam logic [TW-1:0] TIMER_END   = TW'(ACK_LATENCY - 1);
    localparam logic [CW-1:0] CNT_END     = CW'(ACK_COALESCE);
    localparam logic [RW-1:0] REFRESH_END = RW'(FC_REFRESH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [31:0]     dllp_q, dllp_d;
    logic            ackPending_q, ackPending_d;
    logic [11:0]     ackSeq_q, ackSeq_d;
    logic [CW-1:0]   ackCnt_q, ackCnt_d;
    logic [TW-1:0]   ackTimer_q, ackTimer_d;
    logic            nakPending_q, nakPending_d;
    logic [11:0]     nakSeq_q, nakSeq_d;
    logic [2:0]      fcPend_q, fcPend_d;
    logic [7:0]      fcHdr_q [3];
    logic [7:0]      fcHdr_d [3];
    logic [11:0]     fcData_q [3];
    logic [11:0]     fcData_d [3];
    logic [1:0]      rrPtr_q, rrPtr_d;
    logic [RW-1:0]   refreshCnt_q, refreshCnt_d;

    logic            ackDue;
    logic            loadNak;
    logic            loadAck;
    logic [2:0]      loadFc;
    logic [1:0]      rrNext1;
    logic [1:0]      rrNext2;
    logic [1:0]      fcWin;

    function automatic logic [1:0] nextType(input logic [1:0] t);
        return (t == 2'd2) ? 2'd0 : t + 2'd1;
    endfunction

    assign rrNext1 = nextType(rrPtr_q);
    assign rrNext2 = nextType(rrNext1);
    assign fcWin   = fcPend_q[rrPtr_q] ? rrPtr_q : (fcPend_q[rrNext1] ? rrNext1 : rrNext2);
    assign ackDue  = ackPending_q && ((ackTimer_q == TIMER_END) || (ackCnt_q == CNT_END));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dllp_q       <= '0;
            ackPending_q <= 1'b0;
            ackSeq_q     <= '0;
            ackCnt_q     <= '0;
            ackTimer_q   <= '0;
            nakPending_q <= 1'b0;
            nakSeq_q     <= '0;
            fcPend_q     <= '0;
            fcHdr_q      <= '{default: '0};
            fcData_q     <= '{default: '0};
            rrPtr_q      <= 2'd0;
            refreshCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            dllp_q       <= dllp_d;
            ackPending_q <= ackPending_d;
            ackSeq_q     <= ackSeq_d;
            ackCnt_q     <= ackCnt_d;
            ackTimer_q   <= ackTimer_d;
            nakPending_q <= nakPending_d;
            nakSeq_q     <= nakSeq_d;
            fcPend_q     <= fcPend_d;
            fcHdr_q      <= fcHdr_d;
            fcData_q     <= fcData_d;
            rrPtr_q      <= rrPtr_d;
            refreshCnt_q <= refreshCnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dllp_d       = dllp_q;
        ackPending_d = ackPending_q;
        ackSeq_d     = ackSeq_q;
        ackCnt_d     = ackCnt_q;
        ackTimer_d   = ackTimer_q;
        nakPending_d = nakPending_q;
        nakSeq_d     = nakSeq_q;
        fcPend_d     = fcPend_q;
        fcHdr_d      = fcHdr_q;
        fcData_d     = fcData_q;
        rrPtr_d      = rrPtr_q;
        loadNak      = 1'b0;
        loadAck      = 1'b0;
        loadFc       = 3'b000;
        refreshCnt_d = (refreshCnt_q == REFRESH_END) ? '0 : refreshCnt_q + 1'b1;

        if (ackPending_q && (ackTimer_q != TIMER_END)) begin
            ackTimer_d = ackTimer_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (nakPending_q) begin
                    loadNak = 1'b1;
                    dllp_d  = {8'h10, 12'h000, nakSeq_q};
                    state_d = SEND;
                end else if (ackDue) begin
                    loadAck = 1'b1;
                    dllp_d  = {8'h00, 12'h000, ackSeq_q};
                    state_d = SEND;
                end else if (|fcPend_q) begin
                    loadFc[fcWin] = 1'b1;
                    dllp_d  = {2'b10, fcWin, 4'h0, 2'b00, fcHdr_q[fcWin], 2'b00, fcData_q[fcWin]};
                    rrPtr_d = nextType(fcWin);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.dllp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clears from the load come first so a same-cycle request re-arms its flag.
        if (loadNak) begin
            nakPending_d = 1'b0;
        end
        if (loadAck) begin
            ackPending_d = 1'b0;
            ackCnt_d     = '0;
            ackTimer_d   = '0;
        end
        fcPend_d = fcPend_q & ~loadFc;

        if (refreshCnt_q == REFRESH_END) begin
            fcPend_d = 3'b111;
        end
        if (bus.nak_req) begin
            nakPending_d = 1'b1;
            nakSeq_d     = bus.nak_seq;
            ackPending_d = 1'b0;
            ackCnt_d     = '0;
            ackTimer_d   = '0;
        end else if (bus.ack_req) begin
            ackPending_d = 1'b1;
            ackSeq_d     = bus.ack_seq;
            if (ackCnt_d != CNT_END) begin
                ackCnt_d = ackCnt_d + 1'b1;
            end
        end
        if (bus.fc_update_valid && (bus.fc_type != 2'd3)) begin
            fcPend_d[bus.fc_type] = 1'b1;
            fcHdr_d[bus.fc_type]  = bus.fc_hdr;
            fcData_d[bus.fc_type] = bus.fc_data;
        end
    end

    assign bus.dllp_o        = dllp_q;
    assign bus.dllp_valid    = (state_q == SEND);
    assign bus.ack_pending_o = ackPending_q;
    assign bus.nak_pending_o = nakPending_q;
endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Checks dllp_tx_scheduler against a cycle-level reference model built from the arbitration rules,
// with directed scenarios for refresh, coalescing, latency, NAK priority, hold and reset.
module tb_dllp_tx_scheduler;
    localparam int L = 8;
    localparam int C = 4;
    localparam int R = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dllp_tx_if bus();

    dllp_tx_scheduler #(.ACK_LATENCY(L), .ACK_COALESCE(C), .FC_REFRESH(R)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: ACK age is a timestamp rather than a timer, ACK count is unbounded.
    bit          mAckPend;
    int          mAckSeq;
    int          mAckCount;
    int          mAckStart;
    bit          mNakPend;
    int          mNakSeq;
    bit          mFcPend [3];
    int          mFcHdr [3];
    int          mFcData [3];
    int          mRr;
    bit          mBusy;
    logic [31:0] mCur;
    int          mCyc;
    logic [31:0] sentQ [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (model cycle %0d)", tag, observed, expected, mCyc);
        end
    endtask

    function automatic void modelReset();
        mAckPend = 0; mAckSeq = 0; mAckCount = 0; mAckStart = 0;
        mNakPend = 0; mNakSeq = 0;
        for (int t = 0; t < 3; t++) begin
            mFcPend[t] = 0; mFcHdr[t] = 0; mFcData[t] = 0;
        end
        mRr = 0; mBusy = 0; mCur = 32'h0; mCyc = 0;
    endfunction

    function automatic void modelStep(input bit aReq, input int aSeq, input bit nReq, input int nSeq,
                                      input bit fV, input int fT, input int fH, input int fD, input bit rdy);
        int win;
        win = -1;
        if (mBusy) begin
            if (rdy) mBusy = 0;
        end else if (mNakPend) begin
            mCur = 32'h1000_0000 | 32'(mNakSeq);
            mNakPend = 0;
            mBusy = 1;
        end else if (mAckPend && ((mCyc - mAckStart >= L - 1) || (mAckCount >= C))) begin
            mCur = 32'(mAckSeq);
            mAckPend = 0;
            mAckCount = 0;
            mBusy = 1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (win < 0 && mFcPend[(mRr + k) % 3]) win = (mRr + k) % 3;
            end
            if (win >= 0) begin
                mCur = (32'(8 + win) << 28) | (32'(mFcHdr[win]) << 14) | 32'(mFcData[win]);
                mFcPend[win] = 0;
                mRr = (win + 1) % 3;
                mBusy = 1;
            end
        end
        if (mCyc % R == R - 1) begin
            for (int t = 0; t < 3; t++) mFcPend[t] = 1;
        end
        if (nReq) begin
            mNakPend = 1; mNakSeq = nSeq;
            mAckPend = 0; mAckCount = 0;
        end else if (aReq) begin
            if (!mAckPend) mAckStart = mCyc + 1;
            mAckPend = 1; mAckSeq = aSeq; mAckCount++;
        end
        if (fV && fT < 3) begin
            mFcPend[fT] = 1; mFcHdr[fT] = fH; mFcData[fT] = fD;
        end
        mCyc++;
    endfunction

    task automatic applyStimulus(input bit aReq, input int aSeq, input bit nReq, input int nSeq,
                                 input bit fV, input int fT, input int fH, input int fD, input bit rdy);
        bus.ack_req         = aReq;
        bus.ack_seq         = 12'(aSeq);
        bus.nak_req         = nReq;
        bus.nak_seq         = 12'(nSeq);
        bus.fc_update_valid = fV;
        bus.fc_type         = 2'(fT);
        bus.fc_hdr          = 8'(fH);
        bus.fc_data         = 12'(fD);
        bus.dllp_ready      = rdy;
        if (bus.dllp_valid && rdy) sentQ.push_back(bus.dllp_o);
        modelStep(aReq, aSeq, nReq, nSeq, fV, fT, fH, fD, rdy);
        @(posedge clk);
        @(negedge clk);
        checkOutput("valid", 32'(bus.dllp_valid), 32'(mBusy));
        if (mBusy) checkOutput("dllp", bus.dllp_o, mCur);
        checkOutput("ackPending", 32'(bus.ack_pending_o), 32'(mAckPend));
        checkOutput("nakPending", 32'(bus.nak_pending_o), 32'(mNakPend));
    endtask

    task automatic applyIdle(input bit rdy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        bus.ack_req = 0; bus.ack_seq = 0; bus.nak_req = 0; bus.nak_seq = 0;
        bus.fc_update_valid = 0; bus.fc_type = 0; bus.fc_hdr = 0; bus.fc_data = 0;
        bus.dllp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        sentQ.delete();
        checkOutput("resetValid", 32'(bus.dllp_valid), 32'h0);
        checkOutput("resetDllp", bus.dllp_o, 32'h0);
        checkOutput("resetAckPend", 32'(bus.ack_pending_o), 32'h0);
        checkOutput("resetNakPend", 32'(bus.nak_pending_o), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        $display("[TB] starting dllp_tx_scheduler test");

        // Periodic refresh sends P, NP, Cpl two cycles apart.
        resetDut();
        for (int i = 0; i < R; i++) applyIdle(1);
        applyIdle(1);
        checkOutput("refreshP", bus.dllp_o, 32'h8000_0000);
        applyIdle(1); applyIdle(1);
        checkOutput("refreshNP", bus.dllp_o, 32'h9000_0000);
        applyIdle(1); applyIdle(1);
        checkOutput("refreshCpl", bus.dllp_o, 32'hA000_0000);

        // Four ACKs coalesce into one.
        resetDut();
        for (int i = 1; i <= 4; i++) applyStimulus(1, i, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) applyIdle(1);
        checkOutput("coalesceCount", 32'(sentQ.size()), 32'd1);
        checkOutput("coalesceDllp", (sentQ.size() > 0) ? sentQ[0] : 32'hFFFF_FFFF, 32'h0000_0004);

        // Lone ACK goes out when its latency expires.
        resetDut();
        applyStimulus(1, 'h123, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < L - 1; i++) applyIdle(1);
        checkOutput("ackEarlyValid", 32'(bus.dllp_valid), 32'h0);
        applyIdle(1);
        checkOutput("ackLatValid", 32'(bus.dllp_valid), 32'h1);
        checkOutput("ackLatDllp", bus.dllp_o, 32'h0000_0123);
        checkOutput("ackLatPend", 32'(bus.ack_pending_o), 32'h0);

        // NAK supersedes a pending ACK.
        resetDut();
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 'h7FF, 0, 0, 0, 0, 1);
        checkOutput("nakDropsAck", 32'(bus.ack_pending_o), 32'h0);
        for (int i = 0; i < 15; i++) applyIdle(1);
        checkOutput("nakOnlyCount", 32'(sentQ.size()), 32'd1);
        checkOutput("nakOnlyDllp", (sentQ.size() > 0) ? sentQ[0] : 32'hFFFF_FFFF, 32'h1000_07FF);

        // NAK held under backpressure while an NP update queues behind it.
        resetDut();
        applyStimulus(0, 0, 1, 'h055, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, i == 0, 1, 'h20, 'h040, 0);
            checkOutput("nakHold", bus.dllp_o, 32'h1000_0055);
        end
        applyIdle(1);
        applyIdle(1);
        checkOutput("npAfterNak", bus.dllp_o, 32'h9008_0040);

        // Reset during SEND drops the DLLP for good.
        resetDut();
        applyStimulus(0, 0, 1, 'h003, 0, 0, 0, 0, 0);
        applyIdle(0);
        #2 reset = 1'b1;
        #1;
        checkOutput("midResetValid", 32'(bus.dllp_valid), 32'h0);
        checkOutput("midResetDllp", bus.dllp_o, 32'h0);
        resetDut();
        for (int i = 0; i < 20; i++) applyIdle(1);
        checkOutput("noResend", 32'(sentQ.size()), 32'd0);

        // Random traffic against the model, crossing several refresh wraps.
        resetDut();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 5) == 0, int'($urandom_range(0, 4095)),
                          $urandom_range(0, 19) == 0, int'($urandom_range(0, 4095)),
                          $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)),
                          $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
